// File: rtl/bakery_gen.sv
// bakery_gen: NPROC-process Lamport bakery model, one selected process steps per clock.
// Provides stall/wrap ticket-overflow policy and sticky mutual-exclusion/overflow observers.
module bakery_gen #(
    parameter int NPROC     = 2,
    parameter int TKW       = 2,
    parameter int SELW      = 2,
    parameter int BLOCK_OVF = 1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [SELW-1:0]      select,
    input  logic                 pause,
    output logic [NPROC-1:0]     in_cs,
    output logic [NPROC*TKW-1:0] ticket_bus,
    output logic [NPROC*4-1:0]   state_bus,
    output logic                 mutex_err,
    output logic                 ovf_seen
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_TAKE      = 4'd1,
        ST_DOORX     = 4'd2,
        ST_SCAN_INIT = 4'd3,
        ST_SCAN_TEST = 4'd4,
        ST_WAIT_CH   = 4'd5,
        ST_WAIT_TK   = 4'd6,
        ST_SCAN_NEXT = 4'd7,
        ST_CRIT      = 4'd8,
        ST_EXIT      = 4'd9,
        ST_REST      = 4'd10
    } state_t;

    localparam logic [SELW:0] L_NPROC = (SELW+1)'(NPROC);

    state_t           r_state    [NPROC];
    logic [TKW-1:0]   r_ticket   [NPROC];
    logic [SELW-1:0]  r_j        [NPROC];
    logic [NPROC-1:0] r_choosing;
    logic             r_mutex_err;
    logic             r_ovf_seen;

    logic [SELW-1:0]  w_sel;
    state_t           w_cur_state;
    state_t           w_nxt_state;
    logic [TKW-1:0]   w_cur_ticket;
    logic [TKW-1:0]   w_nxt_ticket;
    logic [TKW-1:0]   w_max;
    logic [TKW-1:0]   w_j_ticket;
    logic [SELW-1:0]  w_cur_j;
    logic [SELW-1:0]  w_nxt_j;
    logic             w_cur_choosing;
    logic             w_nxt_choosing;
    logic             w_j_choosing;
    logic             w_ovf_hit;

    // Out-of-range selects alias to process 0
    always_comb begin
        w_sel = ({1'b0, select} < L_NPROC) ? select : '0;
    end

    // Snapshot of the stepping process, its scan target j, and the global max ticket
    always_comb begin
        w_cur_state    = ST_IDLE;
        w_cur_ticket   = '0;
        w_cur_j        = '0;
        w_cur_choosing = 1'b0;
        w_max          = '0;
        for (int i = 0; i < NPROC; i++) begin
            if (w_sel == SELW'(i)) begin
                w_cur_state    = r_state[i];
                w_cur_ticket   = r_ticket[i];
                w_cur_j        = r_j[i];
                w_cur_choosing = r_choosing[i];
            end
            if (r_ticket[i] > w_max) begin
                w_max = r_ticket[i];
            end
        end
        w_j_ticket   = '0;
        w_j_choosing = 1'b0;
        for (int i = 0; i < NPROC; i++) begin
            if (w_cur_j == SELW'(i)) begin
                w_j_ticket   = r_ticket[i];
                w_j_choosing = r_choosing[i];
            end
        end
    end

    always_comb begin
        w_nxt_state    = w_cur_state;
        w_nxt_ticket   = w_cur_ticket;
        w_nxt_j        = w_cur_j;
        w_nxt_choosing = w_cur_choosing;
        w_ovf_hit      = 1'b0;
        case (w_cur_state)
            ST_IDLE: begin
                w_nxt_choosing = 1'b1;
                w_nxt_state    = ST_TAKE;
            end
            ST_TAKE: begin
                if (w_max == '1) begin
                    w_ovf_hit = 1'b1;
                end
                if (!((w_max == '1) && (BLOCK_OVF != 0))) begin
                    w_nxt_ticket = w_max + 1'b1;
                    w_nxt_state  = ST_DOORX;
                end
            end
            ST_DOORX: begin
                w_nxt_choosing = 1'b0;
                w_nxt_state    = ST_SCAN_INIT;
            end
            ST_SCAN_INIT: begin
                w_nxt_j     = '0;
                w_nxt_state = ST_SCAN_TEST;
            end
            ST_SCAN_TEST: begin
                w_nxt_state = ({1'b0, w_cur_j} < L_NPROC) ? ST_WAIT_CH : ST_CRIT;
            end
            ST_WAIT_CH: begin
                if (!w_j_choosing) begin
                    w_nxt_state = ST_WAIT_TK;
                end
            end
            ST_WAIT_TK: begin
                // Lower ticket wins; equal tickets go to the lower index
                if (!((w_j_ticket != '0) &&
                      ((w_j_ticket < w_cur_ticket) ||
                       ((w_j_ticket == w_cur_ticket) && (w_cur_j < w_sel))))) begin
                    w_nxt_state = ST_SCAN_NEXT;
                end
            end
            ST_SCAN_NEXT: begin
                w_nxt_j     = w_cur_j + 1'b1;
                w_nxt_state = ST_SCAN_TEST;
            end
            ST_CRIT: begin
                if (!pause) begin
                    w_nxt_state = ST_EXIT;
                end
            end
            ST_EXIT: begin
                w_nxt_ticket = '0;
                w_nxt_state  = ST_REST;
            end
            ST_REST: begin
                if (!pause) begin
                    w_nxt_state = ST_IDLE;
                end
            end
            default: begin
                w_nxt_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NPROC; i++) begin
                r_state[i]  <= ST_IDLE;
                r_ticket[i] <= '0;
                r_j[i]      <= '0;
            end
            r_choosing  <= '0;
            r_mutex_err <= 1'b0;
            r_ovf_seen  <= 1'b0;
        end else begin
            for (int i = 0; i < NPROC; i++) begin
                if (w_sel == SELW'(i)) begin
                    r_state[i]    <= w_nxt_state;
                    r_ticket[i]   <= w_nxt_ticket;
                    r_j[i]        <= w_nxt_j;
                    r_choosing[i] <= w_nxt_choosing;
                end
            end
            if ($countones(in_cs) > 1) begin
                r_mutex_err <= 1'b1;
            end
            if (w_ovf_hit) begin
                r_ovf_seen <= 1'b1;
            end
        end
    end

    always_comb begin
        in_cs      = '0;
        ticket_bus = '0;
        state_bus  = '0;
        for (int i = 0; i < NPROC; i++) begin
            in_cs[i]                 = (r_state[i] == ST_CRIT);
            ticket_bus[i*TKW +: TKW] = r_ticket[i];
            state_bus[i*4 +: 4]      = r_state[i];
        end
    end

    assign mutex_err = r_mutex_err;
    assign ovf_seen  = r_ovf_seen;

endmodule
